regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file. It is the next-generation replacement for the single-write, dual-read register file in the core datapath. It adds:
- configurable width, depth, read-port count and write-port count
- write-to-read bypass
- a per-register busy scoreboard, so issue logic can detect pending writebacks (load-use, multi-cycle units)

It sits between decode/issue (reads, alloc) and writeback (writes).

Parameters:
XLEN, 32, data width of each register.
NREGS, 32, number of architectural registers; power of two, >=2.
NRD, 2, number of read ports, >=1.
NWR, 2, number of write ports, >=1.
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see only stored state.
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy.
(localparam AW = $clog2(NREGS))

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
rd_addr  input  NRD*AW  read addresses; port r = bits [r*AW +: AW]
rd_data  output  NRD*XLEN  read data; port r = bits [r*XLEN +: XLEN]
rd_busy  output  NRD  1 = register read on port r has an outstanding allocation
wr_en  input  NWR  per-port write enable
wr_addr  input  NWR*AW  write addresses, packed as rd_addr
wr_data  input  NWR*XLEN  write data, packed as rd_data
alloc_en  input  1  mark alloc_addr busy (instruction issued, result pending)
alloc_addr  input  AW  register to mark busy

Behaviour:
- Storage: NREGS x XLEN array plus an NREGS-bit busy vector. All updates occur on posedge clk.
- Reset (reset=1 at posedge):
  - all registers <= 0; busy <= 0; writes and allocs in that cycle are ignored.
  - While reset is high the bypass is disabled, so rd_data reflects stored values.
  - After reset: rd_data = 0 and rd_busy = 0 for every address.
  - Reset asserted mid-operation discards pending busy bits.
- Reads: combinational, zero latency, all NRD ports independent; any address may be read on several ports at once.
- Write: wr_en[w]=1 with a legal address -> register <= wr_data[w] at the next edge.
- ZERO_REG=1:
  - writes and allocs to address 0 are dropped.
  - rd_data for address 0 is always 0 and rd_busy is always 0, including under bypass.
- Write conflict: several enabled ports with the same address -> the highest-index port wins, for both storage and bypass. This is deterministic and is not an error.
- Bypass (BYPASS=1, reset=0): if any enabled write port matches rd_addr[r] (excluding reg 0 when ZERO_REG), rd_data[r] = wr_data of the winning port. Otherwise rd_data[r] = stored value.
- Busy scoreboard:
  - alloc_en sets busy[alloc_addr] at the next edge.
  - An enabled write clears busy[wr_addr] at the next edge.
  - Alloc and write to the same register in the same cycle: busy ends at 1 (alloc wins; the new producer is pending). The data write still takes effect.
  - rd_busy[r] = busy[rd_addr[r]] & ~(BYPASS & matching enabled write this cycle). With BYPASS=0, rd_busy is the raw stored bit.
  - Alloc of an already-busy register: stays busy; no counting.
- No back-pressure, no stalls; every port is accepted every cycle.
- Out-of-range addresses cannot occur (NREGS is a power of two).

Test Plan:
- Reset then read all 32 addresses on both ports -> rd_data=0, rd_busy=0. Write 0xDEADBEEF to r5 during reset -> r5 still reads 0 after reset deasserts.
- Write 0x12345678 to r7 via port 0; next cycle read r7 on ports 0 and 1 -> both 0x12345678. Write 0xFFFFFFFF to r0 -> r0 reads 0.
- BYPASS=1: in the same cycle write 0xA5A5A5A5 to r3 and read r3 -> rd_data=0xA5A5A5A5 combinationally. With BYPASS=0, the same stimulus returns the old value 0, then 0xA5A5A5A5 next cycle.
- Port 0 writes 0x111 and port 1 writes 0x222, both to r9, same cycle -> bypass shows 0x222 and r9 stores 0x222.
- Alloc r4 -> rd_busy=1 next cycle. Write 0x55 to r4 -> rd_busy=0 in that cycle (bypass) and after the edge. Alloc r4 and write r4 in the same cycle -> r4=data, rd_busy stays 1.
- Alloc r6, r8, then assert reset for one cycle -> busy cleared, rd_busy=0 for r6 and r8. Alloc r0 -> rd_busy for r0 stays 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and a per-register
// busy scoreboard that tracks results still waiting for writeback.
module regfile_mp #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned NRD      = 2,
   parameter int unsigned NWR      = 2,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1,
   localparam int unsigned AW      = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                alloc_en,
   input  logic [AW-1:0]       alloc_addr
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   logic [AW-1:0]    wa;
   logic [AW-1:0]    ra;
   logic [XLEN-1:0]  rdat;
   logic             rbsy;

   function automatic logic is_zero_reg(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Ports are visited in ascending order so the highest-index writer wins.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      wa     = '0;
      for (int w = 0; w < NWR; w++) begin
         wa = wr_addr[w*AW +: AW];
         if (wr_en[w] && !is_zero_reg(wa)) begin
            regs_d[wa] = wr_data[w*XLEN +: XLEN];
            busy_d[wa] = 1'b0;
         end
      end
      // Applied after writes: a new producer issued this cycle keeps the register busy.
      if (alloc_en && !is_zero_reg(alloc_addr)) begin
         busy_d[alloc_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '{default: '0};
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      ra      = '0;
      rdat    = '0;
      rbsy    = 1'b0;
      for (int r = 0; r < NRD; r++) begin
         ra   = rd_addr[r*AW +: AW];
         rdat = regs_q[ra];
         rbsy = busy_q[ra];
         if ((BYPASS != 0) && !reset) begin
            for (int w = 0; w < NWR; w++) begin
               if (wr_en[w] && (wr_addr[w*AW +: AW] == ra)) begin
                  rdat = wr_data[w*XLEN +: XLEN];
                  rbsy = 1'b0;
               end
            end
         end
         if (is_zero_reg(ra)) begin
            rdat = '0;
            rbsy = 1'b0;
         end
         rd_data[r*XLEN +: XLEN] = rdat;
         rd_busy[r]              = rbsy;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one bypassing and one non-bypassing instance
// share all stimulus; expected reads are queued and checked on the falling edge.
module tb_regfile_mp;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [2*AW-1:0]   rd_addr;
   logic [2*XLEN-1:0] rd_data_b, rd_data_n;
   logic [1:0]        rd_busy_b, rd_busy_n;
   logic [1:0]        wr_en;
   logic [2*AW-1:0]   wr_addr;
   logic [2*XLEN-1:0] wr_data;
   logic              alloc_en;
   logic [AW-1:0]     alloc_addr;

   always #5 clk = ~clk;

   regfile_mp #(.BYPASS(1)) dut_b (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr)
   );

   regfile_mp #(.BYPASS(0)) dut_n (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr)
   );

   typedef struct {
      bit          nb;
      int          port;
      logic [31:0] data;
      logic        busy;
      int          step;
   } exp_t;

   exp_t sb[$];
   int   step    = 0;
   int   n_check = 0;
   int   n_fail  = 0;

   task automatic push_exp(input bit nb, input int port, input logic [31:0] data,
                           input logic busy);
      exp_t e;
      e.nb = nb; e.port = port; e.data = data; e.busy = busy; e.step = step;
      sb.push_back(e);
   endtask

   task automatic exp_both(input int port, input logic [31:0] data, input logic busy);
      push_exp(1'b0, port, data, busy);
      push_exp(1'b1, port, data, busy);
   endtask

   task automatic idle();
      reset    = 1'b0;
      wr_en    = '0;
      alloc_en = 1'b0;
   endtask

   task automatic rd(input int a0, input int a1);
      rd_addr[0 +: AW]  = AW'(a0);
      rd_addr[AW +: AW] = AW'(a1);
   endtask

   task automatic wr(input int port, input int a, input logic [31:0] d);
      wr_en[port]              = 1'b1;
      wr_addr[port*AW +: AW]   = AW'(a);
      wr_data[port*XLEN +: XLEN] = d;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      step++;
      idle();
   endtask

   // Monitor: drains every expectation queued for this cycle.
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] ad;
      logic        ab;
      while (sb.size() != 0) begin
         e  = sb.pop_front();
         ad = e.nb ? rd_data_n[e.port*XLEN +: XLEN] : rd_data_b[e.port*XLEN +: XLEN];
         ab = e.nb ? rd_busy_n[e.port] : rd_busy_b[e.port];
         n_check++;
         if (ad !== e.data) begin
            n_fail++;
            $display("FAIL step%0d %s port%0d rd_data: got %h expected %h", e.step,
                     e.nb ? "nobyp" : "byp", e.port, ad, e.data);
         end
         n_check++;
         if (ab !== e.busy) begin
            n_fail++;
            $display("FAIL step%0d %s port%0d rd_busy: got %b expected %b", e.step,
                     e.nb ? "nobyp" : "byp", e.port, ab, e.busy);
         end
      end
   end

   initial begin
      idle();
      reset      = 1'b1;
      rd_addr    = '0;
      wr_addr    = '0;
      wr_data    = '0;
      alloc_addr = '0;
      @(posedge clk);
      #1;
      // Second reset cycle: write to r5 must be ignored, bypass disabled.
      reset = 1'b1;
      wr(0, 5, 32'hDEADBEEF);
      rd(5, 5);
      exp_both(0, 32'h0, 1'b0);
      exp_both(1, 32'h0, 1'b0);
      next();

      for (int a = 0; a < 32; a++) begin
         rd(a, 31 - a);
         exp_both(0, 32'h0, 1'b0);
         exp_both(1, 32'h0, 1'b0);
         next();
      end

      wr(0, 7, 32'h12345678);
      wr(1, 0, 32'hFFFFFFFF);
      rd(7, 0);
      push_exp(1'b0, 0, 32'h12345678, 1'b0);
      push_exp(1'b1, 0, 32'h0, 1'b0);
      exp_both(1, 32'h0, 1'b0);
      next();
      rd(7, 7);
      exp_both(0, 32'h12345678, 1'b0);
      exp_both(1, 32'h12345678, 1'b0);
      next();
      rd(0, 0);
      exp_both(0, 32'h0, 1'b0);
      exp_both(1, 32'h0, 1'b0);
      next();

      wr(0, 3, 32'hA5A5A5A5);
      rd(3, 3);
      push_exp(1'b0, 0, 32'hA5A5A5A5, 1'b0);
      push_exp(1'b0, 1, 32'hA5A5A5A5, 1'b0);
      push_exp(1'b1, 0, 32'h0, 1'b0);
      push_exp(1'b1, 1, 32'h0, 1'b0);
      next();
      rd(3, 3);
      exp_both(0, 32'hA5A5A5A5, 1'b0);
      exp_both(1, 32'hA5A5A5A5, 1'b0);
      next();

      // Same-address write conflict: port 1 must win.
      wr(0, 9, 32'h111);
      wr(1, 9, 32'h222);
      rd(9, 3);
      push_exp(1'b0, 0, 32'h222, 1'b0);
      push_exp(1'b1, 0, 32'h0, 1'b0);
      exp_both(1, 32'hA5A5A5A5, 1'b0);
      next();
      rd(9, 9);
      exp_both(0, 32'h222, 1'b0);
      exp_both(1, 32'h222, 1'b0);
      next();

      alloc_en = 1'b1; alloc_addr = 5'd4;
      rd(4, 9);
      exp_both(0, 32'h0, 1'b0);
      next();
      rd(4, 4);
      exp_both(0, 32'h0, 1'b1);
      exp_both(1, 32'h0, 1'b1);
      next();
      wr(1, 4, 32'h55);
      rd(4, 4);
      push_exp(1'b0, 0, 32'h55, 1'b0);
      push_exp(1'b1, 0, 32'h0, 1'b1);
      next();
      rd(4, 4);
      exp_both(0, 32'h55, 1'b0);
      next();
      alloc_en = 1'b1; alloc_addr = 5'd4;
      wr(0, 4, 32'h77);
      rd(4, 4);
      push_exp(1'b0, 0, 32'h77, 1'b0);
      push_exp(1'b1, 0, 32'h55, 1'b0);
      next();
      rd(4, 4);
      exp_both(0, 32'h77, 1'b1);
      exp_both(1, 32'h77, 1'b1);
      next();

      alloc_en = 1'b1; alloc_addr = 5'd6;
      next();
      alloc_en = 1'b1; alloc_addr = 5'd8;
      next();
      reset = 1'b1;
      rd(6, 8);
      exp_both(0, 32'h0, 1'b1);
      exp_both(1, 32'h0, 1'b1);
      next();
      rd(6, 8);
      exp_both(0, 32'h0, 1'b0);
      exp_both(1, 32'h0, 1'b0);
      next();
      rd(4, 9);
      exp_both(0, 32'h0, 1'b0);
      exp_both(1, 32'h0, 1'b0);
      next();

      alloc_en = 1'b1; alloc_addr = 5'd0;
      wr(1, 0, 32'h1234);
      rd(0, 0);
      exp_both(0, 32'h0, 1'b0);
      next();
      rd(0, 0);
      exp_both(0, 32'h0, 1'b0);
      exp_both(1, 32'h0, 1'b0);
      next();

      @(negedge clk);
      #1;
      n_check++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending entries expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
      $finish;
   end

endmodule
